// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the two-requester logic unit arbiter.
// Op-codes and FSM state encodings.
package logic_unit_arbiter_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/logic_unit_arbiter_logic_unit.sv
// Purely combinational k-bit bitwise unit.
// NOT only looks at operand A.
module bitwise_logic_unit
    import logic_unit_arbiter_pkg::*;
#(
    parameter int k = 4
) (
    input  logic [k-1:0] inputA,
    input  logic [k-1:0] inputB,
    input  logic [1:0]   op,
    output logic [k-1:0] outputC
);

    // Select the bitwise function by op-code
    always_comb begin
        outputC = '0;
        unique case (op)
            OP_AND:  outputC = inputA & inputB;
            OP_OR:   outputC = inputA | inputB;
            OP_XOR:  outputC = inputA ^ inputB;
            OP_NOT:  outputC = ~inputA;
            default: outputC = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise unit between two
// requesters; one operation in flight, result held until accepted.
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int k     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [k-1:0]     req0_inputA,
    input  logic [k-1:0]     req0_inputB,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [k-1:0]     req1_inputA,
    input  logic [k-1:0]     req1_inputB,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [k-1:0]     resp_outputC,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             id_q, id_d;
    logic [1:0]       op_q, op_d;
    logic [k-1:0]     a_q, a_d;
    logic [k-1:0]     b_q, b_d;
    logic [k-1:0]     c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [k-1:0]     unit_c;
    logic             grant0, grant1;

    bitwise_logic_unit #(.k(k)) u_unit (
        .inputA  (a_q),
        .inputB  (b_q),
        .op      (op_q),
        .outputC (unit_c)
    );

    // On a tie the requester that was not served last wins
    assign grant0 = req0_valid & (~req1_valid | last_q);
    assign grant1 = req1_valid & (~req0_valid | ~last_q);

    assign resp_id      = id_q;
    assign resp_outputC = c_q;
    assign done_count   = cnt_q;

    // Next-state, operand capture and handshake outputs
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        id_d       = id_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        cnt_d      = cnt_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant0) begin
                    req0_ready = 1'b1;
                    id_d       = 1'b0;
                    op_d       = req0_op;
                    a_d        = req0_inputA;
                    b_d        = req0_inputB;
                    state_d    = EXEC;
                end else if (grant1) begin
                    req1_ready = 1'b1;
                    id_d       = 1'b1;
                    op_d       = req1_op;
                    a_d        = req1_inputA;
                    b_d        = req1_inputB;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                busy    = 1'b1;
                c_d     = unit_c;
                state_d = RESP;
            end
            RESP: begin
                busy       = 1'b1;
                resp_valid = 1'b1;
                if (resp_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    last_d  = id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            op_q    <= 2'b00;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter.
// Inputs change on negedge; outputs are sampled #1 after negedge.
module tb_logic_unit_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready;
    logic [1:0] req0_op;
    logic [3:0] req0_inputA, req0_inputB;
    logic       req1_valid, req1_ready;
    logic [1:0] req1_op;
    logic [3:0] req1_inputA, req1_inputB;
    logic       resp_valid, resp_ready, resp_id, busy;
    logic [3:0] resp_outputC;
    logic [7:0] done_count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.k(4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_op      (req0_op),
        .req0_inputA  (req0_inputA),
        .req0_inputB  (req0_inputB),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_op      (req1_op),
        .req1_inputA  (req1_inputA),
        .req1_inputB  (req1_inputB),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_outputC (resp_outputC),
        .busy         (busy),
        .done_count   (done_count)
    );

    task automatic idle_inputs();
        req0_valid = 0; req0_op = 0; req0_inputA = 0; req0_inputB = 0;
        req1_valid = 0; req1_op = 0; req1_inputA = 0; req1_inputB = 0;
        resp_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        n_chk++;
        if ({req0_ready, req1_ready, resp_valid, resp_id, busy} !== 5'b0 ||
            resp_outputC !== 4'h0 || done_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b%b rv=%b id=%b busy=%b C=%h cnt=%0d want all 0",
                     req0_ready, req1_ready, resp_valid, resp_id, busy,
                     resp_outputC, done_count);
        end
        rst = 0;
    endtask

    task automatic test_single();
        do_reset();
        req0_valid = 1; req0_op = 2'b00;
        req0_inputA = 4'b1111; req0_inputB = 4'b1010;
        #1;
        n_chk++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_accept: rdy0=%b rdy1=%b busy=%b want 1 0 0",
                     req0_ready, req1_ready, busy);
        end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0;
        #1;
        n_chk++;
        if (busy !== 1'b1 || resp_valid !== 1'b0 || req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_exec: busy=%b rv=%b rdy0=%b want 1 0 0",
                     busy, resp_valid, req0_ready);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        n_chk++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_outputC !== 4'b1010) begin
            n_fail++;
            $display("FAIL single_resp: rv=%b id=%b C=%b want 1 0 1010",
                     resp_valid, resp_id, resp_outputC);
        end
        resp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 0;
        #1;
        n_chk++;
        if (done_count !== 8'd1 || resp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: cnt=%0d rv=%b busy=%b want 1 0 0",
                     done_count, resp_valid, busy);
        end
    endtask

    task automatic test_both_valid();
        do_reset();
        req0_valid = 1; req0_op = 2'b01;
        req0_inputA = 4'b0101; req0_inputB = 4'b0011;
        req1_valid = 1; req1_op = 2'b10;
        req1_inputA = 4'b1100; req1_inputB = 4'b1010;
        #1;
        n_chk++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL both_first_grant: rdy0=%b rdy1=%b want 1 0",
                     req0_ready, req1_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0;
        #1;
        n_chk++;
        if (req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL both_exec_hold: rdy1=%b want 0", req1_ready);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        n_chk++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_outputC !== 4'b0111) begin
            n_fail++;
            $display("FAIL both_resp0: rv=%b id=%b C=%b want 1 0 0111",
                     resp_valid, resp_id, resp_outputC);
        end
        resp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 0;
        #1;
        n_chk++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL both_second_grant: rdy0=%b rdy1=%b want 0 1",
                     req0_ready, req1_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req1_valid = 0;
        @(posedge clk);
        @(negedge clk);
        #1;
        n_chk++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_outputC !== 4'b0110) begin
            n_fail++;
            $display("FAIL both_resp1: rv=%b id=%b C=%b want 1 1 0110",
                     resp_valid, resp_id, resp_outputC);
        end
        resp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 0;
        #1;
        n_chk++;
        if (done_count !== 8'd2) begin
            n_fail++;
            $display("FAIL both_count: cnt=%0d want 2", done_count);
        end
    endtask

    task automatic test_alternate();
        logic [3:0] want_c;
        do_reset();
        req0_valid = 1; req0_op = 2'b00;
        req0_inputA = 4'b1111; req0_inputB = 4'b0011;
        req1_valid = 1; req1_op = 2'b01;
        req1_inputA = 4'b0000; req1_inputB = 4'b1000;
        resp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_chk++;
            if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                n_fail++;
                $display("FAIL alt_grant_%0d: rdy0=%b rdy1=%b want %b %b",
                         i, req0_ready, req1_ready, i % 2 == 0, i % 2 == 1);
            end
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            #1;
            want_c = (i % 2 == 0) ? 4'b0011 : 4'b1000;
            n_chk++;
            if (resp_id !== (i % 2 == 1) || resp_outputC !== want_c) begin
                n_fail++;
                $display("FAIL alt_resp_%0d: id=%b C=%b want %b %b",
                         i, resp_id, resp_outputC, i % 2 == 1, want_c);
            end
            @(posedge clk);
            @(negedge clk);
        end
        req0_valid = 0;
        req1_valid = 0;
        resp_ready = 0;
        #1;
        n_chk++;
        if (done_count !== 8'd4) begin
            n_fail++;
            $display("FAIL alt_count: cnt=%0d want 4", done_count);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req0_valid = 1; req0_op = 2'b10;
        req0_inputA = 4'b1001; req0_inputB = 4'b0011;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0;
        req1_valid = 1; req1_op = 2'b00;
        req1_inputA = 4'b0110; req1_inputB = 4'b0111;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            n_chk++;
            if (resp_valid !== 1'b1 || resp_id !== 1'b0 ||
                resp_outputC !== 4'b1010 || req0_ready !== 1'b0 ||
                req1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: rv=%b id=%b C=%b rdy=%b%b want 1 0 1010 00",
                         i, resp_valid, resp_id, resp_outputC,
                         req0_ready, req1_ready);
            end
            @(posedge clk);
        end
        @(negedge clk);
        resp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 0;
        #1;
        n_chk++;
        if (req1_ready !== 1'b1 || done_count !== 8'd1) begin
            n_fail++;
            $display("FAIL bp_release: rdy1=%b cnt=%0d want 1 1",
                     req1_ready, done_count);
        end
        @(posedge clk);
        @(negedge clk);
        req1_valid = 0;
        @(posedge clk);
        @(negedge clk);
        #1;
        n_chk++;
        if (resp_id !== 1'b1 || resp_outputC !== 4'b0110) begin
            n_fail++;
            $display("FAIL bp_next: id=%b C=%b want 1 0110", resp_id, resp_outputC);
        end
        resp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req1_valid = 1; req1_op = 2'b11;
        req1_inputA = 4'b0110; req1_inputB = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        req1_valid = 0;
        resp_ready = 1;
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        n_chk++;
        if ({req0_ready, req1_ready, resp_valid, resp_id, busy} !== 5'b0 ||
            resp_outputC !== 4'h0 || done_count !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: rdy=%b%b rv=%b id=%b busy=%b C=%h cnt=%0d want all 0",
                     req0_ready, req1_ready, resp_valid, resp_id, busy,
                     resp_outputC, done_count);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        n_chk++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_no_resp: rv=%b busy=%b want 0 0", resp_valid, busy);
        end
        resp_ready = 0;
        req1_valid = 1;
        @(posedge clk);
        @(negedge clk);
        req1_valid = 0;
        @(posedge clk);
        @(negedge clk);
        #1;
        n_chk++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_outputC !== 4'b1001) begin
            n_fail++;
            $display("FAIL midrst_after: rv=%b id=%b C=%b want 1 1 1001",
                     resp_valid, resp_id, resp_outputC);
        end
        resp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        req0_op = 2'b00; req0_inputA = 4'b1100; req0_inputB = 4'b0110;
        resp_ready = 1;
        for (int i = 0; i < 256; i++) begin
            req0_valid = 1;
            @(posedge clk);
            @(negedge clk);
            req0_valid = 0;
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            if (i == 254) begin
                #1;
                n_chk++;
                if (done_count !== 8'd255) begin
                    n_fail++;
                    $display("FAIL wrap_255: cnt=%0d want 255", done_count);
                end
            end
        end
        resp_ready = 0;
        #1;
        n_chk++;
        if (done_count !== 8'd0 || resp_outputC !== 4'b0100) begin
            n_fail++;
            $display("FAIL wrap_zero: cnt=%0d C=%b want 0 0100",
                     done_count, resp_outputC);
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_single();
        test_both_valid();
        test_alternate();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
